instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 14 +
 rtl/instr_fetch_if.sv | 34 +++
 rtl/instr_fetch_fetch_buf.sv | 95 +++++++++
 rtl/instr_fetch.sv | 111 +++++++++++
 tb/tb_instr_fetch.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: the fetch FSM state encoding, the NOP
// bubble presented when no instruction is available, and the PC stride.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RSP = 2'd1,
      DISCARD  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus.
//   imem_req    : fetch unit requests a read of imem_addr
//   imem_addr   : word-aligned read address
//   imem_gnt    : memory accepts the request this cycle
//   imem_rvalid : read data valid, in order, at least one cycle after gnt
//   imem_rdata  : fetched instruction word
// master = fetch unit, slave = instruction memory.
interface instr_fetch_if #(
   parameter int unsigned DataWidth = 32
) ();

   logic                 imem_req;
   logic [DataWidth-1:0] imem_addr;
   logic                 imem_gnt;
   logic                 imem_rvalid;
   logic [DataWidth-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/instr_fetch_fetch_buf.sv
// Two-entry instruction/PC FIFO between instruction memory and IF_ID.
//   clock, reset : clock and synchronous active-high reset
//   flush        : drop every entry (branch/jump redirect)
//   push         : write {push_instr, push_pc}
//   pop          : consume the head entry
//   head_valid   : head entry holds a real instruction
//   head_instr   : head instruction, NOP when empty
//   head_pc      : head PC, zero when empty
//   count        : number of occupied entries (0..2)
module fetch_buf
   import instr_fetch_pkg::*;
#(
   parameter int unsigned DataWidth = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 push,
   input  logic [DataWidth-1:0] push_instr,
   input  logic [DataWidth-1:0] push_pc,
   input  logic                 pop,
   output logic                 head_valid,
   output logic [DataWidth-1:0] head_instr,
   output logic [DataWidth-1:0] head_pc,
   output logic [1:0]           count
);

   logic [DataWidth-1:0] instr_q [2];
   logic [DataWidth-1:0] instr_d [2];
   logic [DataWidth-1:0] pc_q    [2];
   logic [DataWidth-1:0] pc_d    [2];
   logic                 rd_ptr_q, rd_ptr_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic [1:0]           count_q, count_d;
   logic                 do_push, do_pop;

   always_comb begin
      instr_d  = instr_q;
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      do_pop  = pop && (count_q != 2'd0);
      // A full buffer still takes a push when the head leaves in the same cycle.
      do_push = push && ((count_q != 2'd2) || do_pop);

      if (do_push) begin
         instr_d[wr_ptr_q] = push_instr;
         pc_d[wr_ptr_q]    = push_pc;
         wr_ptr_d          = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: it is only visible behind count_q.
   always_ff @(posedge clock) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
   end

   always_comb begin
      head_valid = (count_q != 2'd0);
      head_instr = head_valid ? instr_q[rd_ptr_q] : DataWidth'(NOP_INSTR);
      head_pc    = head_valid ? pc_q[rd_ptr_q] : '0;
      count      = count_q;
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one outstanding word read at a time,
// buffers up to two returned instructions and presents the head to IF_ID.
//   clock, reset     : clock and synchronous active-high reset
//   stall            : decode cannot accept; hold the presented entry
//   redirect         : branch/jump taken (same signal as the IF_ID flush)
//   redirect_pc      : new fetch address, low two bits ignored
//   imem             : instruction-memory bus (master side)
//   if_valid         : Instruction_OUT/PC_OUT carry a real instruction
//   Instruction_OUT  : instruction to IF_ID Instruction_IN (NOP when empty)
//   PC_OUT           : PC of Instruction_OUT to IF_ID PC_IN (zero when empty)
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned          DataWidth = 32,
   parameter logic [DataWidth-1:0] ResetPC   = 32'h0000_0000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic [DataWidth-1:0] redirect_pc,
   instr_fetch_if.master        imem,
   output logic                 if_valid,
   output logic [DataWidth-1:0] Instruction_OUT,
   output logic [DataWidth-1:0] PC_OUT
);

   localparam logic [DataWidth-1:0] AlignMask = ~DataWidth'(3);
   localparam logic [DataWidth-1:0] PcIncr    = DataWidth'(PC_INCR);

   fetch_state_e         state_q, state_d;
   logic [DataWidth-1:0] fetch_pc_q, fetch_pc_d;
   logic [DataWidth-1:0] req_pc_q, req_pc_d;
   logic                 fetch_req;
   logic                 buf_push, buf_pop;
   logic [1:0]           buf_count;

   fetch_buf #(
      .DataWidth (DataWidth)
   ) u_fetch_buf (
      .clock      (clock),
      .reset      (reset),
      .flush      (redirect),
      .push       (buf_push),
      .push_instr (imem.imem_rdata),
      .push_pc    (req_pc_q),
      .pop        (buf_pop),
      .head_valid (if_valid),
      .head_instr (Instruction_OUT),
      .head_pc    (PC_OUT),
      .count      (buf_count)
   );

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      fetch_req  = 1'b0;
      buf_push   = 1'b0;
      // Flush wins over a stalled or accepted head entry.
      buf_pop    = if_valid && !stall && !redirect;

      unique case (state_q)
         IDLE: begin
            // Requesting only with at most one entry buffered guarantees the
            // single outstanding response always has a free slot.
            fetch_req = !reset && !redirect && (buf_count <= 2'd1);
            if (fetch_req && imem.imem_gnt) begin
               req_pc_d = fetch_pc_q & AlignMask;
               state_d  = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (imem.imem_rvalid) begin
               buf_push   = !redirect;
               fetch_pc_d = req_pc_q + PcIncr;
               state_d    = IDLE;
            end
         end
         DISCARD: begin
            if (imem.imem_rvalid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A redirect while a response is still owed must wait it out in
      // DISCARD so the stale word is never taken for the new stream.
      if (redirect) begin
         fetch_pc_d = redirect_pc & AlignMask;
         state_d    = ((state_q != IDLE) && !imem.imem_rvalid) ? DISCARD : IDLE;
      end

      imem.imem_req  = fetch_req;
      imem.imem_addr = fetch_pc_q & AlignMask;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= ResetPC;
         req_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   localparam int unsigned DW  = 32;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic          clock       = 1'b0;
   logic          reset       = 1'b1;
   logic          stall       = 1'b0;
   logic          redirect    = 1'b0;
   logic [DW-1:0] redirect_pc = '0;
   logic          if_valid;
   logic [DW-1:0] Instruction_OUT;
   logic [DW-1:0] PC_OUT;

   int n_checks = 0;
   int n_fail   = 0;

   instr_fetch_if #(.DataWidth(DW)) imem ();

   instr_fetch #(
      .DataWidth (DW),
      .ResetPC   (32'h0000_0000)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem            (imem.master),
      .if_valid        (if_valid),
      .Instruction_OUT (Instruction_OUT),
      .PC_OUT          (PC_OUT)
   );

   always #5 clock = ~clock;

   // Memory model: one request at a time, response mem_lat cycles after grant.
   logic          mem_pend = 1'b0;
   int unsigned   mem_wait = 0;
   int unsigned   mem_lat  = 1;
   logic [DW-1:0] mem_addr = '0;

   assign imem.imem_gnt    = imem.imem_req & ~mem_pend;
   assign imem.imem_rvalid = mem_pend && (mem_wait == 0);
   assign imem.imem_rdata  = mem_addr ^ KEY;

   always @(posedge clock) begin
      if (imem.imem_req && imem.imem_gnt) begin
         mem_pend <= 1'b1;
         mem_addr <= imem.imem_addr;
         mem_wait <= mem_lat - 1;
      end else if (mem_pend) begin
         if (mem_wait == 0) mem_pend <= 1'b0;
         else               mem_wait <= mem_wait - 1;
      end
   end

   // Entries accepted by decode: {PC, instruction}.
   logic [63:0] popq [$];
   always @(negedge clock) begin
      if (!reset && if_valid && !stall && !redirect)
         popq.push_back({PC_OUT, Instruction_OUT});
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset    = 1'b1;
      stall    = 1'b0;
      redirect = 1'b0;
      mem_lat  = 1;
      repeat (3) tick();
      reset = 1'b0;
      popq.delete();
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      @(negedge clock);
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
      n_checks++; if (Instruction_OUT !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 00000000", Instruction_OUT); end
      n_checks++; if (PC_OUT !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 00000000", PC_OUT); end
      n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem.imem_req); end
      tick();
      reset = 1'b0;
      @(negedge clock);
      n_checks++; if (imem.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", imem.imem_req); end
      n_checks++; if (imem.imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h want 00000000", imem.imem_addr); end
      tick();
      tick();
      // Cycle 2: IDLE with one entry buffered, so a request would normally be up.
      reset = 1'b1;
      @(negedge clock);
      n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_cycle_req: got %b want 0", imem.imem_req); end
      tick();
      @(negedge clock);
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flush_valid: got %b want 0", if_valid); end
      tick();
   endtask

   task automatic test_stream;
      logic [63:0] got;
      logic [31:0] pc;
      do_reset();
      repeat (13) tick();
      n_checks++; if (popq.size() != 6) begin n_fail++; $display("FAIL stream_count: got %0d want 6", popq.size()); end
      for (int i = 0; i < 6; i++) begin
         pc  = 32'(4 * i);
         got = (i < popq.size()) ? popq[i] : '1;
         n_checks++;
         if (got !== {pc, pc ^ KEY}) begin
            n_fail++;
            $display("FAIL stream_entry%0d: got pc=%h instr=%h want pc=%h instr=%h", i, got[63:32], got[31:0], pc, pc ^ KEY);
         end
      end
   endtask

   task automatic test_stall;
      logic [63:0] got;
      logic [31:0] pc;
      do_reset();
      stall = 1'b1;
      repeat (4) tick();
      @(negedge clock);
      n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_full_req: got %b want 0", imem.imem_req); end
      n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b want 1", if_valid); end
      n_checks++; if (PC_OUT !== 32'h0) begin n_fail++; $display("FAIL stall_hold_pc: got %h want 00000000", PC_OUT); end
      tick();
      stall = 1'b0;
      repeat (8) tick();
      n_checks++; if (popq.size() != 5) begin n_fail++; $display("FAIL stall_count: got %0d want 5", popq.size()); end
      for (int i = 0; i < 5; i++) begin
         pc  = 32'(4 * i);
         got = (i < popq.size()) ? popq[i] : '1;
         n_checks++;
         if (got !== {pc, pc ^ KEY}) begin
            n_fail++;
            $display("FAIL stall_entry%0d: got pc=%h instr=%h want pc=%h instr=%h", i, got[63:32], got[31:0], pc, pc ^ KEY);
         end
      end
   endtask

   task automatic test_redirect_wait;
      do_reset();
      mem_lat = 3;
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0102;
      @(negedge clock);
      n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_c1_req: got %b want 0", imem.imem_req); end
      tick();
      redirect = 1'b0;
      mem_lat  = 1;
      @(negedge clock);
      n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_c2_req: got %b want 0", imem.imem_req); end
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_c2_valid: got %b want 0", if_valid); end
      tick();
      @(negedge clock);
      n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_c3_req: got %b want 0", imem.imem_req); end
      tick();
      @(negedge clock);
      n_checks++; if (imem.imem_req !== 1'b1) begin n_fail++; $display("FAIL rw_c4_req: got %b want 1", imem.imem_req); end
      n_checks++; if (imem.imem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL rw_addr: got %h want 00000100", imem.imem_addr); end
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_c4_valid: got %b want 0", if_valid); end
      tick();
      @(negedge clock);
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_c5_valid: got %b want 0", if_valid); end
      tick();
      @(negedge clock);
      n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL rw_c6_valid: got %b want 1", if_valid); end
      n_checks++; if (PC_OUT !== 32'h0000_0100) begin n_fail++; $display("FAIL rw_pc: got %h want 00000100", PC_OUT); end
      n_checks++; if (Instruction_OUT !== 32'hA5A5_0100) begin n_fail++; $display("FAIL rw_instr: got %h want a5a50100", Instruction_OUT); end
      tick();
   endtask

   task automatic test_redirect_rvalid;
      do_reset();
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0040;
      tick();
      redirect = 1'b0;
      @(negedge clock);
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rr_c2_valid: got %b want 0", if_valid); end
      n_checks++; if (imem.imem_req !== 1'b1) begin n_fail++; $display("FAIL rr_req: got %b want 1", imem.imem_req); end
      n_checks++; if (imem.imem_addr !== 32'h0000_0040) begin n_fail++; $display("FAIL rr_addr: got %h want 00000040", imem.imem_addr); end
      tick();
      @(negedge clock);
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rr_c3_valid: got %b want 0", if_valid); end
      tick();
      @(negedge clock);
      n_checks++; if (PC_OUT !== 32'h0000_0040) begin n_fail++; $display("FAIL rr_pc: got %h want 00000040", PC_OUT); end
      n_checks++; if (Instruction_OUT !== 32'hA5A5_0040) begin n_fail++; $display("FAIL rr_instr: got %h want a5a50040", Instruction_OUT); end
      tick();
   endtask

   task automatic test_wrap;
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clock);
      n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_redir_req: got %b want 0", imem.imem_req); end
      tick();
      redirect = 1'b0;
      @(negedge clock);
      n_checks++; if (imem.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h want fffffffc", imem.imem_addr); end
      n_checks++; if (imem.imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_req_latency: got %b want 1", imem.imem_req); end
      tick();
      tick();
      @(negedge clock);
      n_checks++; if (PC_OUT !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc0: got %h want fffffffc", PC_OUT); end
      n_checks++; if (Instruction_OUT !== 32'h5A5A_FFFC) begin n_fail++; $display("FAIL wrap_instr0: got %h want 5a5afffc", Instruction_OUT); end
      n_checks++; if (imem.imem_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_addr1: got %h want 00000000", imem.imem_addr); end
      tick();
      tick();
      @(negedge clock);
      n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid1: got %b want 1", if_valid); end
      n_checks++; if (PC_OUT !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc1: got %h want 00000000", PC_OUT); end
      n_checks++; if (Instruction_OUT !== 32'hA5A5_0000) begin n_fail++; $display("FAIL wrap_instr1: got %h want a5a50000", Instruction_OUT); end
      tick();
   endtask

   task automatic test_redirect_stall;
      do_reset();
      stall = 1'b1;
      repeat (4) tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick();
      redirect = 1'b0;
      @(negedge clock);
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid: got %b want 0", if_valid); end
      n_checks++; if (Instruction_OUT !== 32'h0) begin n_fail++; $display("FAIL rs_nop: got %h want 00000000", Instruction_OUT); end
      n_checks++; if (PC_OUT !== 32'h0) begin n_fail++; $display("FAIL rs_pc_zero: got %h want 00000000", PC_OUT); end
      n_checks++; if (imem.imem_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL rs_addr: got %h want 00000200", imem.imem_addr); end
      tick();
      stall = 1'b0;
      tick();
      @(negedge clock);
      n_checks++; if (PC_OUT !== 32'h0000_0200) begin n_fail++; $display("FAIL rs_pc: got %h want 00000200", PC_OUT); end
      tick();
   endtask

   task automatic test_reset_mid;
      do_reset();
      mem_lat = 2;
      tick();
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      mem_lat = 1;
      @(negedge clock);
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rm_c2_valid: got %b want 0", if_valid); end
      n_checks++; if (imem.imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_req: got %b want 1", imem.imem_req); end
      n_checks++; if (imem.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_addr: got %h want 00000000", imem.imem_addr); end
      tick();
      @(negedge clock);
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rm_c3_valid: got %b want 0", if_valid); end
      tick();
      @(negedge clock);
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rm_c4_valid: got %b want 0", if_valid); end
      tick();
      @(negedge clock);
      n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL rm_c5_valid: got %b want 1", if_valid); end
      n_checks++; if (Instruction_OUT !== 32'hA5A5_0000) begin n_fail++; $display("FAIL rm_instr: got %h want a5a50000", Instruction_OUT); end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_wait();
      test_redirect_rvalid();
      test_wrap();
      test_redirect_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
